// File: rtl/ctrl_ajuste_relogio_if.sv
// Signal bundle between the clock-adjust controller and its surroundings:
// tick and raw keys in, counter controls and display blanking out.
interface ctrl_ajuste_relogio_if;
    logic       tick_1hz;
    logic       btn_modo;
    logic       btn_inc;
    logic       en_seg;
    logic       inc_min;
    logic       inc_hora;
    logic       clr_seg;
    logic [1:0] modo;
    logic       apaga_hora;
    logic       apaga_min;

    // Environment side: drives tick and keys, observes controls.
    modport master (
        output tick_1hz, btn_modo, btn_inc,
        input  en_seg, inc_min, inc_hora, clr_seg, modo, apaga_hora, apaga_min
    );

    // Controller side.
    modport slave (
        input  tick_1hz, btn_modo, btn_inc,
        output en_seg, inc_min, inc_hora, clr_seg, modo, apaga_hora, apaga_min
    );
endinterface

// File: rtl/ctrl_ajuste_relogio.sv
// Clock-adjust controller: debounces the mode and increment keys, walks the
// RODANDO -> AJUSTE_HORA -> AJUSTE_MIN cycle and issues one-cycle increment /
// clear pulses to the time counters, plus a blink phase for the field being set.
module ctrl_ajuste_relogio #(
    parameter int unsigned DB_CICLOS = 16
) (
    input logic                    CLOCK_50,
    input logic                    reset,
    ctrl_ajuste_relogio_if.slave   bus
);
    localparam int unsigned CntW = $clog2(DB_CICLOS);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CICLOS - 1);

    typedef enum logic [1:0] {
        StRodando    = 2'b00,
        StAjusteHora = 2'b01,
        StAjusteMin  = 2'b10
    } state_e;

    // Index 0 = mode key, index 1 = increment key (both active-low).
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_prev_q;
    logic [1:0]      press_q;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];

    state_e state_q, state_d;
    logic   piscar_q, piscar_d;
    logic   inc_hora_q, inc_hora_d;
    logic   inc_min_q, inc_min_d;
    logic   clr_seg_q, clr_seg_d;
    logic   ev_modo, ev_inc;
    logic   em_ajuste;

    assign raw     = {bus.btn_inc, bus.btn_modo};
    assign ev_modo = press_q[0];
    assign ev_inc  = press_q[1];

    // Debounce: level only follows the synchronized key after CntMax+1 differing cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Key front end: synchronizers, debounced levels and registered press pulses.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_prev_q <= 2'b11;
            press_q    <= 2'b00;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            // Press = debounced 1->0; release produces nothing.
            press_q    <= deb_prev_q & ~deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
        end
    end

    // Mode FSM next state, pulse requests and blink phase.
    always_comb begin
        state_d    = state_q;
        inc_hora_d = 1'b0;
        inc_min_d  = 1'b0;
        clr_seg_d  = 1'b0;
        piscar_d   = piscar_q;
        // A mode event always takes priority over a same-cycle increment event.
        case (state_q)
            StRodando: begin
                if (ev_modo) state_d = StAjusteHora;
            end
            StAjusteHora: begin
                if (ev_modo)     state_d    = StAjusteMin;
                else if (ev_inc) inc_hora_d = 1'b1;
            end
            StAjusteMin: begin
                if (ev_modo) begin
                    state_d   = StRodando;
                    clr_seg_d = 1'b1;
                end else if (ev_inc) begin
                    inc_min_d = 1'b1;
                end
            end
            default: state_d = StRodando;
        endcase
        // Entering an adjust state restarts the blink with the digits visible.
        if (state_d != state_q && state_d != StRodando) begin
            piscar_d = 1'b0;
        end else if (em_ajuste && bus.tick_1hz) begin
            piscar_d = ~piscar_q;
        end
    end

    assign em_ajuste = (state_q == StAjusteHora) || (state_q == StAjusteMin);

    // FSM state and registered output pulses.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= StRodando;
            piscar_q   <= 1'b0;
            inc_hora_q <= 1'b0;
            inc_min_q  <= 1'b0;
            clr_seg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            piscar_q   <= piscar_d;
            inc_hora_q <= inc_hora_d;
            inc_min_q  <= inc_min_d;
            clr_seg_q  <= clr_seg_d;
        end
    end

    assign bus.modo       = state_q;
    assign bus.en_seg     = bus.tick_1hz && (state_q == StRodando);
    assign bus.inc_hora   = inc_hora_q;
    assign bus.inc_min    = inc_min_q;
    assign bus.clr_seg    = clr_seg_q;
    assign bus.apaga_hora = piscar_q && (state_q == StAjusteHora);
    assign bus.apaga_min  = piscar_q && (state_q == StAjusteMin);
endmodule

// File: tb/tb_ctrl_ajuste_relogio.sv
// Directed bench for ctrl_ajuste_relogio with a short debounce (4 cycles).
// Step index k counts rising edges, edge 1 being the first to sample a new key level.
// A held key yields its press pulse after edge DB+3; the FSM consumes it on edge DB+4.
module tb_ctrl_ajuste_relogio;
    localparam int unsigned DB = 4;

    logic clk;
    logic rst_n;
    ctrl_ajuste_relogio_if bus ();

    ctrl_ajuste_relogio #(.DB_CICLOS(DB)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit tick_en = 0;

    int n_hora, n_min, n_clr, n_en, n_chg, first_chg, n_clr_at_chg, step_idx;
    int n_overlap = 0;
    logic [1:0] prev_modo;

    // One clock: sample point is 1 time unit after the edge; tick is updated then.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.tick_1hz = tick_en && (cyc % 10 == 0);
        #1;
    endtask

    task automatic clear_counts();
        n_hora = 0; n_min = 0; n_clr = 0; n_en = 0; n_chg = 0;
        first_chg = -1; n_clr_at_chg = 0; step_idx = 0;
        prev_modo = bus.modo;
    endtask

    task automatic sample();
        if (bus.inc_hora) n_hora++;
        if (bus.inc_min)  n_min++;
        if (bus.clr_seg)  n_clr++;
        if (bus.en_seg)   n_en++;
        if (int'(bus.inc_hora) + int'(bus.inc_min) + int'(bus.clr_seg) > 1) n_overlap++;
        if (bus.modo !== prev_modo) begin
            n_chg++;
            if (first_chg < 0) first_chg = step_idx;
            if (bus.clr_seg) n_clr_at_chg++;
            prev_modo = bus.modo;
        end
    endtask

    // Hold the selected keys low for low_cyc edges, observe for total_cyc edges.
    task automatic run(input bit m, input bit i, input int low_cyc, input int total_cyc);
        clear_counts();
        bus.btn_modo = ~m;
        bus.btn_inc  = ~i;
        for (int k = 1; k <= total_cyc; k++) begin
            step();
            step_idx = k;
            sample();
            if (k == low_cyc) begin
                bus.btn_modo = 1'b1;
                bus.btn_inc  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.en_seg, bus.inc_min, bus.inc_hora, bus.clr_seg, bus.apaga_hora,
             bus.apaga_min} !== 6'b0 || bus.modo !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got modo=%b others=%b required modo=00 others=000000",
                     bus.modo, {bus.en_seg, bus.inc_min, bus.inc_hora, bus.clr_seg,
                                bus.apaga_hora, bus.apaga_min});
        end
    endtask

    task automatic test_running_ticks();
        int n_tick = 0;
        int bad = 0;
        tick_en = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.tick_1hz) n_tick++;
            if (bus.en_seg !== bus.tick_1hz || bus.modo !== 2'b00 ||
                {bus.inc_min, bus.inc_hora, bus.clr_seg, bus.apaga_hora, bus.apaga_min} !== 5'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_en_seg_mirror: got %0d bad cycles required 0", bad);
        end
        checks++;
        if (n_tick != 4) begin
            errors++;
            $display("FAIL run_tick_count: got %0d required 4", n_tick);
        end
    endtask

    task automatic test_modo_cycle();
        run(1, 0, 20, 32);
        checks++;
        if (bus.modo !== 2'b01 || n_chg != 1 || first_chg != int'(DB) + 4) begin
            errors++;
            $display("FAIL modo_to_hora: got modo=%b changes=%0d at_edge=%0d required 01 1 %0d",
                     bus.modo, n_chg, first_chg, DB + 4);
        end
        run(1, 0, 20, 32);
        checks++;
        if (bus.modo !== 2'b10 || n_chg != 1 || n_clr != 0) begin
            errors++;
            $display("FAIL modo_to_min: got modo=%b changes=%0d clr=%0d required 10 1 0",
                     bus.modo, n_chg, n_clr);
        end
        run(1, 0, 20, 32);
        checks++;
        if (bus.modo !== 2'b00 || n_chg != 1 || n_clr != 1 || n_clr_at_chg != 1) begin
            errors++;
            $display("FAIL modo_to_run: got modo=%b changes=%0d clr=%0d clr_on_edge=%0d required 00 1 1 1",
                     bus.modo, n_chg, n_clr, n_clr_at_chg);
        end
    endtask

    task automatic test_inc_hora();
        int tot_hora = 0, tot_min = 0, tot_en = 0, single = 0;
        run(1, 0, 20, 32);
        for (int p = 0; p < 3; p++) begin
            run(0, 1, 10, 22);
            tot_hora += n_hora; tot_min += n_min; tot_en += n_en;
            if (n_hora == 1) single++;
        end
        checks++;
        if (tot_hora != 3 || single != 3) begin
            errors++;
            $display("FAIL inc_hora_pulses: got %0d (%0d single) required 3 (3)", tot_hora, single);
        end
        checks++;
        if (tot_min != 0 || tot_en != 0 || bus.modo !== 2'b01) begin
            errors++;
            $display("FAIL inc_hora_side: got inc_min=%0d en_seg=%0d modo=%b required 0 0 01",
                     tot_min, tot_en, bus.modo);
        end
    endtask

    task automatic test_simultaneous();
        run(1, 1, 20, 32);
        checks++;
        if (bus.modo !== 2'b10 || n_hora != 0 || n_min != 0) begin
            errors++;
            $display("FAIL simultaneous: got modo=%b hora=%0d min=%0d required 10 0 0",
                     bus.modo, n_hora, n_min);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        for (int r = 0; r < 6; r++) begin
            bus.btn_inc = 1'b0;
            step(); sample();
            step(); sample();
            bus.btn_inc = 1'b1;
            step(); sample();
            step(); sample();
        end
        for (int k = 0; k < 10; k++) begin
            step(); sample();
        end
        checks++;
        if (n_min != 0 || n_hora != 0 || bus.modo !== 2'b10) begin
            errors++;
            $display("FAIL glitch_rejected: got min=%0d hora=%0d modo=%b required 0 0 10",
                     n_min, n_hora, bus.modo);
        end
    endtask

    task automatic test_inc_min();
        run(0, 1, 10, 22);
        checks++;
        if (n_min != 1 || n_hora != 0 || bus.modo !== 2'b10) begin
            errors++;
            $display("FAIL inc_min_pulse: got min=%0d hora=%0d modo=%b required 1 0 10",
                     n_min, n_hora, bus.modo);
        end
    endtask

    task automatic test_blink_and_reset();
        logic [3:0] seq = 4'b0;
        int nrec = 0;
        int hora_bad = 0;
        bit entered = 0;
        bit pt;
        run(1, 0, 20, 32);   // -> 00
        run(1, 0, 20, 32);   // -> 01
        bus.btn_modo = 1'b0;
        for (int k = 1; k <= 120 && nrec < 4; k++) begin
            pt = bus.tick_1hz;
            step();
            if (k == 20) bus.btn_modo = 1'b1;
            if (entered && pt) begin
                seq[3 - nrec] = bus.apaga_min;
                if (bus.apaga_hora !== 1'b0) hora_bad++;
                nrec++;
            end
            if (!entered && bus.modo === 2'b10) entered = 1;
        end
        bus.btn_modo = 1'b1;
        checks++;
        if (nrec != 4 || seq !== 4'b1010) begin
            errors++;
            $display("FAIL blink_apaga_min: got seq=%b (%0d ticks) required 1010 (4)", seq, nrec);
        end
        checks++;
        if (hora_bad != 0) begin
            errors++;
            $display("FAIL blink_apaga_hora: got %0d high samples required 0", hora_bad);
        end
        tick_en = 0;
        bus.tick_1hz = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.en_seg, bus.inc_min, bus.inc_hora, bus.clr_seg, bus.apaga_hora,
             bus.apaga_min} !== 6'b0 || bus.modo !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got modo=%b others=%b required 00 000000",
                     bus.modo, {bus.en_seg, bus.inc_min, bus.inc_hora, bus.clr_seg,
                                bus.apaga_hora, bus.apaga_min});
        end
    endtask

    task automatic test_held_across_reset();
        bus.btn_modo = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_counts();
        for (int k = 1; k <= 30; k++) begin
            step();
            step_idx = k;
            sample();
            if (k == 20) bus.btn_modo = 1'b1;
        end
        checks++;
        if (bus.modo !== 2'b01 || n_chg != 1 || first_chg != int'(DB) + 4) begin
            errors++;
            $display("FAIL held_across_reset: got modo=%b changes=%0d at_edge=%0d required 01 1 %0d",
                     bus.modo, n_chg, first_chg, DB + 4);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.btn_modo = 1'b1;
        bus.btn_inc  = 1'b1;
        bus.tick_1hz = 1'b0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        test_running_ticks();
        test_modo_cycle();
        test_inc_hora();
        test_simultaneous();
        test_glitch();
        test_inc_min();
        test_blink_and_reset();
        test_held_across_reset();
        checks++;
        if (n_overlap != 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles required 0", n_overlap);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
